// File: rtl/gpu_ucode_sequencer_pkg.sv
// Shared definitions for the GPU microcode sequencer: micro-op field layout,
// opcode and register-selector codes, and the sequencer FSM encoding.
package gpu_ucode_sequencer_pkg;

  // Micro-op field layout (20-bit word)
  localparam int UOP_W    = 20;
  localparam int FIELD_W  = 5;
  localparam int OPC_LSB  = 15;
  localparam int DST_LSB  = 10;
  localparam int SRC1_LSB = 5;
  localparam int SRC0_LSB = 0;
  localparam int LIT_W    = 10;
  localparam int TGT_W    = 8;

  typedef enum logic [4:0] {
    OP_GNOP   = 5'd0,
    OP_GWRL   = 5'd1,
    OP_GWRR   = 5'd2,
    OP_GADD   = 5'd3,
    OP_GADDL  = 5'd4,
    OP_GSUBL  = 5'd5,
    OP_GJNZ   = 5'd6,
    OP_GJZ    = 5'd7,
    OP_GGOTO  = 5'd8,
    OP_GRVMEM = 5'd9,
    OP_GWBG   = 5'd10
  } opcode_e;

  // Register selectors
  localparam logic [4:0] SEL_GNULL     = 5'd0;
  localparam logic [4:0] SEL_STATE     = 5'd1;
  localparam logic [4:0] SEL_CUR_TILE  = 5'd2;
  localparam logic [4:0] SEL_TILE_ROW  = 5'd3;
  localparam logic [4:0] SEL_BLOCK_SEL = 5'd4;
  localparam logic [4:0] SEL_VMEM_ADDR = 5'd5;
  localparam logic [4:0] SEL_BGMOFFSET = 5'd6;
  localparam logic [4:0] SEL_BGTOFFSET = 5'd7;
  localparam logic [4:0] SEL_BG_ROWOFF = 5'd8;
  localparam logic [4:0] SEL_VMEM_DATA = 5'd9;
  localparam logic [4:0] SEL_VDATA_SHL = 5'd10;
  localparam logic [4:0] SEL_BH        = 5'd11;
  localparam logic [4:0] SEL_BL        = 5'd12;
  localparam logic [4:0] SEL_LY        = 5'd13;
  localparam logic [4:0] SEL_R1        = 5'd14;
  localparam logic [4:0] SEL_R2        = 5'd15;

  typedef enum logic {
    ST_EXEC  = 1'b0,
    ST_VWAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/gpu_ucode_sequencer_if.sv
// ROM fetch, VRAM read and BG-buffer write signals of the microcode sequencer.
interface gpu_ucode_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int VMEM_DW = 8
);
  logic [7:0]         oUopAddr;
  logic [19:0]        iUop;
  logic [DATA_W-1:0]  oVmemAddr;
  logic               oVmemReq;
  logic               iVmemAck;
  logic [VMEM_DW-1:0] iVmemData;
  logic               oBgWrite;
  logic [15:0]        oBgData;
  logic [5:0]         oBgBlockSel;

  modport master (
    output oUopAddr, oVmemAddr, oVmemReq, oBgWrite, oBgData, oBgBlockSel,
    input  iUop, iVmemAck, iVmemData
  );

  modport slave (
    input  oUopAddr, oVmemAddr, oVmemReq, oBgWrite, oBgData, oBgBlockSel,
    output iUop, iVmemAck, iVmemData
  );
endinterface

// File: rtl/gpu_ucode_regfile.sv
// Sequencer scratch/register file: two combinational read ports, one write
// port, read-only views of input ports and the latched VRAM byte. Writes to
// read-only or unmapped selectors are silently dropped.
module gpu_ucode_regfile
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int VMEM_DW = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [4:0]         i_raddr_a,
  input  logic [4:0]         i_raddr_b,
  output logic [DATA_W-1:0]  o_rdata_a,
  output logic [DATA_W-1:0]  o_rdata_b,
  input  logic               i_we,
  input  logic [4:0]         i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic               i_vmem_we,
  input  logic [VMEM_DW-1:0] i_vmem_data,
  input  logic [DATA_W-1:0]  i_bg_map_offset,
  input  logic [DATA_W-1:0]  i_bg_tile_offset,
  output logic [DATA_W-1:0]  o_vmem_addr,
  output logic [3:0]         o_state,
  output logic [7:0]         o_ly,
  output logic [7:0]         o_bh,
  output logic [7:0]         o_bl,
  output logic [5:0]         o_block_sel
);

  logic [DATA_W-1:0]  r_state, r_cur_tile, r_tile_row, r_block_sel, r_vmem_addr;
  logic [DATA_W-1:0]  r_bh, r_bl, r_ly, r_r1, r_r2;
  logic [VMEM_DW-1:0] r_vmem_data;
  logic [DATA_W-1:0]  w_vdata_ext;
  logic [DATA_W-1:0]  w_view [0:31];

  assign w_vdata_ext = {{(DATA_W-VMEM_DW){1'b0}}, r_vmem_data};

  // Selector-indexed view of every readable value; unmapped selectors read 0
  always_comb begin
    for (int i = 0; i < 32; i++) w_view[i] = '0;
    w_view[SEL_GNULL]     = '0;
    w_view[SEL_STATE]     = r_state;
    w_view[SEL_CUR_TILE]  = r_cur_tile;
    w_view[SEL_TILE_ROW]  = r_tile_row;
    w_view[SEL_BLOCK_SEL] = r_block_sel;
    w_view[SEL_VMEM_ADDR] = r_vmem_addr;
    w_view[SEL_BGMOFFSET] = i_bg_map_offset;
    w_view[SEL_BGTOFFSET] = i_bg_tile_offset;
    w_view[SEL_BG_ROWOFF] = r_tile_row;
    w_view[SEL_VMEM_DATA] = w_vdata_ext;
    w_view[SEL_VDATA_SHL] = w_vdata_ext << 4;
    w_view[SEL_BH]        = r_bh;
    w_view[SEL_BL]        = r_bl;
    w_view[SEL_LY]        = r_ly;
    w_view[SEL_R1]        = r_r1;
    w_view[SEL_R2]        = r_r2;
  end

  assign o_rdata_a   = w_view[i_raddr_a];
  assign o_rdata_b   = w_view[i_raddr_b];
  assign o_vmem_addr = r_vmem_addr;
  assign o_state     = r_state[3:0];
  assign o_ly        = r_ly[7:0];
  assign o_bh        = r_bh[7:0];
  assign o_bl        = r_bl[7:0];
  assign o_block_sel = r_block_sel[5:0];

  // Writable registers and the VRAM byte latch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= '0;
      r_cur_tile  <= '0;
      r_tile_row  <= '0;
      r_block_sel <= '0;
      r_vmem_addr <= '0;
      r_bh        <= '0;
      r_bl        <= '0;
      r_ly        <= '0;
      r_r1        <= '0;
      r_r2        <= '0;
      r_vmem_data <= '0;
    end else begin
      if (i_vmem_we) r_vmem_data <= i_vmem_data;
      if (i_we) begin
        case (i_waddr)
          SEL_STATE:     r_state     <= i_wdata;
          SEL_CUR_TILE:  r_cur_tile  <= i_wdata;
          SEL_TILE_ROW:  r_tile_row  <= i_wdata;
          SEL_BLOCK_SEL: r_block_sel <= i_wdata;
          SEL_VMEM_ADDR: r_vmem_addr <= i_wdata;
          SEL_BH:        r_bh        <= i_wdata;
          SEL_BL:        r_bl        <= i_wdata;
          SEL_LY:        r_ly        <= i_wdata;
          SEL_R1:        r_r1        <= i_wdata;
          SEL_R2:        r_r2        <= i_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/gpu_ucode_sequencer.sv
// GPU microcode sequencer: fetches from the ucode ROM, executes one micro-op
// per cycle, stalls on grvmem until the VRAM read is acknowledged.
//
// state | meaning
// EXEC  | decode and execute iUop at PC every enabled cycle
// VWAIT | VRAM read outstanding; oVmemReq held until ack, PC parked on grvmem
module gpu_ucode_sequencer #(
  parameter int DATA_W  = 16,
  parameter int VMEM_DW = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      iEnable,
  gpu_ucode_sequencer_if.master     bus_m,
  input  logic [DATA_W-1:0]         iBgMapOffset,
  input  logic [DATA_W-1:0]         iBgTileOffset,
  output logic [7:0]                oLy,
  output logic [3:0]                oState,
  output logic                      oIllegalOp
);
  import gpu_ucode_sequencer_pkg::*;

  seq_state_e        r_fsm, w_fsm_d;
  logic [7:0]        r_pc, w_pc_d, w_pc_inc;
  logic              r_z, w_z_d;
  logic              r_vmem_req, w_req_d;
  logic              r_ack_pend, w_pend_d;
  logic              r_bg_write, w_bg_write_d;
  logic [15:0]       r_bg_data, w_bg_data_d;
  logic [5:0]        r_bg_block_sel, w_bg_sel_d;
  logic              r_illegal, w_illegal_d;

  opcode_e           w_opcode;
  logic [4:0]        w_dest, w_src1, w_src0, w_raddr_a;
  logic [DATA_W-1:0] w_lit, w_rdata_a, w_rdata_b, w_result;
  logic [7:0]        w_target;
  logic              w_alu, w_vmem_we;
  logic [7:0]        w_bh, w_bl;
  logic [5:0]        w_block_sel;

  assign w_opcode = opcode_e'(bus_m.iUop[OPC_LSB +: FIELD_W]);
  assign w_dest   = bus_m.iUop[DST_LSB +: FIELD_W];
  assign w_src1   = bus_m.iUop[SRC1_LSB +: FIELD_W];
  assign w_src0   = bus_m.iUop[SRC0_LSB +: FIELD_W];
  assign w_lit    = {{(DATA_W-LIT_W){1'b0}}, bus_m.iUop[LIT_W-1:0]};
  assign w_target = bus_m.iUop[TGT_W-1:0];
  assign w_pc_inc = r_pc + 8'd1;

  // gaddl/gsubl read-modify-write their destination through port A
  assign w_raddr_a = (w_opcode == OP_GADDL || w_opcode == OP_GSUBL) ? w_dest : w_src1;

  gpu_ucode_regfile #(.DATA_W(DATA_W), .VMEM_DW(VMEM_DW)) u_regfile (
    .Clock            (Clock),
    .Reset            (Reset),
    .i_raddr_a        (w_raddr_a),
    .i_raddr_b        (w_src0),
    .o_rdata_a        (w_rdata_a),
    .o_rdata_b        (w_rdata_b),
    .i_we             (w_alu),
    .i_waddr          (w_dest),
    .i_wdata          (w_result),
    .i_vmem_we        (w_vmem_we),
    .i_vmem_data      (bus_m.iVmemData),
    .i_bg_map_offset  (iBgMapOffset),
    .i_bg_tile_offset (iBgTileOffset),
    .o_vmem_addr      (bus_m.oVmemAddr),
    .o_state          (oState),
    .o_ly             (oLy),
    .o_bh             (w_bh),
    .o_bl             (w_bl),
    .o_block_sel      (w_block_sel)
  );

  // Next-state, PC, flag and strobe decode
  always_comb begin
    w_fsm_d      = r_fsm;
    w_pc_d       = r_pc;
    w_z_d        = r_z;
    w_req_d      = r_vmem_req;
    w_pend_d     = r_ack_pend;
    w_bg_write_d = 1'b0;
    w_bg_data_d  = r_bg_data;
    w_bg_sel_d   = r_bg_block_sel;
    w_illegal_d  = 1'b0;
    w_alu        = 1'b0;
    w_result     = '0;
    w_vmem_we    = 1'b0;
    case (r_fsm)
      ST_EXEC: begin
        if (iEnable) begin
          w_pc_d = w_pc_inc;
          case (w_opcode)
            OP_GNOP:   ;
            OP_GWRL:   begin w_alu = 1'b1; w_result = w_lit; end
            OP_GWRR:   begin w_alu = 1'b1; w_result = w_rdata_a; end
            OP_GADD:   begin w_alu = 1'b1; w_result = w_rdata_a + w_rdata_b; end
            OP_GADDL:  begin w_alu = 1'b1; w_result = w_rdata_a + w_lit; end
            OP_GSUBL:  begin w_alu = 1'b1; w_result = w_rdata_a - w_lit; end
            OP_GJNZ:   if (!r_z) w_pc_d = w_target;
            OP_GJZ:    if (r_z) w_pc_d = w_target;
            OP_GGOTO:  w_pc_d = w_target;
            OP_GRVMEM: begin
              w_pc_d  = r_pc;
              w_req_d = 1'b1;
              w_fsm_d = ST_VWAIT;
            end
            OP_GWBG: begin
              w_bg_write_d = 1'b1;
              w_bg_data_d  = {w_bh, w_bl};
              w_bg_sel_d   = w_block_sel;
            end
            default: w_illegal_d = 1'b1;
          endcase
          if (w_alu) w_z_d = (w_result == '0);
        end
      end
      ST_VWAIT: begin
        // An ack taken while disabled is remembered so the stall can end later
        if (bus_m.iVmemAck && !r_ack_pend) begin
          w_vmem_we = 1'b1;
          w_req_d   = 1'b0;
        end
        if (iEnable && (bus_m.iVmemAck || r_ack_pend)) begin
          w_fsm_d  = ST_EXEC;
          w_pc_d   = w_pc_inc;
          w_pend_d = 1'b0;
        end else if (bus_m.iVmemAck) begin
          w_pend_d = 1'b1;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_fsm          <= ST_EXEC;
      r_pc           <= '0;
      r_z            <= 1'b0;
      r_vmem_req     <= 1'b0;
      r_ack_pend     <= 1'b0;
      r_bg_write     <= 1'b0;
      r_bg_data      <= '0;
      r_bg_block_sel <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_fsm          <= w_fsm_d;
      r_pc           <= w_pc_d;
      r_z            <= w_z_d;
      r_vmem_req     <= w_req_d;
      r_ack_pend     <= w_pend_d;
      r_bg_write     <= w_bg_write_d;
      r_bg_data      <= w_bg_data_d;
      r_bg_block_sel <= w_bg_sel_d;
      r_illegal      <= w_illegal_d;
    end
  end

  assign bus_m.oUopAddr    = r_pc;
  assign bus_m.oVmemReq    = r_vmem_req;
  assign bus_m.oBgWrite    = r_bg_write;
  assign bus_m.oBgData     = r_bg_data;
  assign bus_m.oBgBlockSel = r_bg_block_sel;
  assign oIllegalOp        = r_illegal;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Bench for gpu_ucode_sequencer: ROM array, VRAM responder, instruction-level
// reference model compared every cycle, plus hand-computed directed checks.
module tb_gpu_ucode_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iEnable = 1'b1;
  logic [15:0] iBgMapOffset = 16'h0;
  logic [15:0] iBgTileOffset = 16'h0;
  logic [7:0]  oLy;
  logic [3:0]  oState;
  logic        oIllegalOp;

  gpu_ucode_sequencer_if #(.DATA_W(16), .VMEM_DW(8)) bus ();

  gpu_ucode_sequencer #(.DATA_W(16), .VMEM_DW(8)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iEnable       (iEnable),
    .bus_m         (bus.master),
    .iBgMapOffset  (iBgMapOffset),
    .iBgTileOffset (iBgTileOffset),
    .oLy           (oLy),
    .oState        (oState),
    .oIllegalOp    (oIllegalOp)
  );

  always #5 Clock = ~Clock;

  logic [19:0] rom [0:255];
  assign bus.iUop = rom[bus.oUopAddr];

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] enc(input int unsigned op, input int unsigned d,
                                      input int unsigned s1, input int unsigned s0);
    return {op[4:0], d[4:0], s1[4:0], s0[4:0]};
  endfunction

  function automatic logic [19:0] enc_l(input int unsigned op, input int unsigned d,
                                        input int unsigned lit);
    return {op[4:0], d[4:0], lit[9:0]};
  endfunction

  // ---------------- reference model (instruction-level) ----------------
  logic [7:0]  m_pc;
  logic [15:0] m_reg [0:15];
  logic        m_z, m_req, m_wait, m_bgw, m_ill;
  logic [15:0] m_bgdata;
  logic [5:0]  m_bgsel;
  logic [7:0]  m_vdata;
  logic [19:0] m_u;
  logic [4:0]  m_op, m_d, m_s1, m_s0;
  logic [15:0] m_lit, m_res;
  logic        m_wr;
  logic [7:0]  m_nxt;

  function automatic logic [15:0] rd(input logic [4:0] s);
    case (s)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
      5'd11, 5'd12, 5'd13, 5'd14, 5'd15: return m_reg[s[3:0]];
      5'd6:  return iBgMapOffset;
      5'd7:  return iBgTileOffset;
      5'd8:  return m_reg[3];
      5'd9:  return {8'h00, m_vdata};
      5'd10: return {4'h0, m_vdata, 4'h0};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_pc = 8'd0;
      for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
      m_z = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_bgw = 1'b0; m_ill = 1'b0;
      m_bgdata = 16'h0; m_bgsel = 6'h0; m_vdata = 8'h0;
    end else begin
      m_bgw = 1'b0;
      m_ill = 1'b0;
      if (m_wait) begin
        if (m_req && bus.iVmemAck) begin
          m_vdata = bus.iVmemData;
          m_req   = 1'b0;
        end
        if (!m_req && iEnable) begin
          m_wait = 1'b0;
          m_pc   = m_pc + 8'd1;
        end
      end else if (iEnable) begin
        m_u   = rom[m_pc];
        m_op  = m_u[19:15];
        m_d   = m_u[14:10];
        m_s1  = m_u[9:5];
        m_s0  = m_u[4:0];
        m_lit = {6'd0, m_u[9:0]};
        m_nxt = m_pc + 8'd1;
        m_wr  = 1'b1;
        m_res = 16'h0;
        case (m_op)
          5'd1: m_res = m_lit;
          5'd2: m_res = rd(m_s1);
          5'd3: m_res = rd(m_s1) + rd(m_s0);
          5'd4: m_res = rd(m_d) + m_lit;
          5'd5: m_res = rd(m_d) - m_lit;
          default: m_wr = 1'b0;
        endcase
        case (m_op)
          5'd6: if (!m_z) m_nxt = m_u[7:0];
          5'd7: if (m_z) m_nxt = m_u[7:0];
          5'd8: m_nxt = m_u[7:0];
          5'd9: begin m_req = 1'b1; m_wait = 1'b1; m_nxt = m_pc; end
          5'd10: begin
            m_bgw    = 1'b1;
            m_bgdata = {m_reg[11][7:0], m_reg[12][7:0]};
            m_bgsel  = m_reg[4][5:0];
          end
          default: if (m_op > 5'd10) m_ill = 1'b1;
        endcase
        if (m_wr) begin
          m_z = (m_res == 16'h0);
          if (m_d inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15})
            m_reg[m_d[3:0]] = m_res;
        end
        m_pc = m_nxt;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge Clock) begin
    #1;
    if (chk_en) begin
      chk("uop_addr",  32'(bus.oUopAddr),  32'(m_pc));
      chk("vmem_req",  32'(bus.oVmemReq),  32'(m_req));
      chk("vmem_addr", 32'(bus.oVmemAddr), 32'(m_reg[5]));
      chk("ly",        32'(oLy),           32'(m_reg[13][7:0]));
      chk("state",     32'(oState),        32'(m_reg[1][3:0]));
      chk("illegal",   32'(oIllegalOp),    32'(m_ill));
      chk("bg_write",  32'(bus.oBgWrite),  32'(m_bgw));
      if (m_bgw) begin
        chk("bg_data", 32'(bus.oBgData),     32'(m_bgdata));
        chk("bg_sel",  32'(bus.oBgBlockSel), 32'(m_bgsel));
      end
    end
  end

  // ---------------- VRAM responder ----------------
  int   ack_lat = 1;
  logic rand_lat = 1'b0;
  logic ack_rand = 1'b0;
  logic spurious = 1'b0;
  logic force_ack = 1'b0;
  logic [7:0] ack_byte = 8'h00;

  initial begin
    int cnt;
    int unsigned t;
    cnt = 0;
    bus.iVmemAck  = 1'b0;
    bus.iVmemData = 8'h00;
    forever begin
      @(negedge Clock);
      #1;
      t = $urandom;
      bus.iVmemAck  = 1'b0;
      bus.iVmemData = t[7:0];
      if (force_ack) begin
        bus.iVmemAck  = 1'b1;
        bus.iVmemData = ack_byte;
      end else if (m_req) begin
        cnt++;
        if (cnt == ack_lat) begin
          bus.iVmemAck = 1'b1;
          if (!ack_rand) bus.iVmemData = ack_byte;
        end
      end else begin
        cnt = 0;
        if (rand_lat) ack_lat = int'($urandom_range(1, 4));
        if (spurious && $urandom_range(0, 9) == 0) bus.iVmemAck = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 20'h0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic logic [19:0] rand_uop();
    int unsigned r, op;
    r = $urandom_range(0, 99);
    if (r < 8) op = $urandom_range(11, 31);
    else       op = $urandom_range(0, 10);
    return enc(op, $urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 31));
  endfunction

  initial begin
    int reqs;
    int unsigned t;
    clear_rom();
    @(negedge Clock);

    // reset values, then gnop; gwrl state,3
    rom[1] = enc_l(1, 1, 3);
    do_reset();
    chk_en = 1'b1;
    chk("rst_pc",    32'(bus.oUopAddr),   32'd0);
    chk("rst_req",   32'(bus.oVmemReq),   32'd0);
    chk("rst_state", 32'(oState),         32'd0);
    chk("rst_bgw",   32'(bus.oBgWrite),   32'd0);
    chk("rst_ill",   32'(oIllegalOp),     32'd0);
    step(1); chk("t1_pc1", 32'(bus.oUopAddr), 32'd1);
    step(1); chk("t1_pc2", 32'(bus.oUopAddr), 32'd2);
    chk("t1_state", 32'(oState), 32'd3);

    // zero flag: taken gjz
    clear_rom();
    rom[0] = enc_l(1, 14, 'h10);
    rom[1] = enc_l(5, 14, 'h10);
    rom[2] = enc_l(7, 0, 40);
    do_reset();
    step(3); chk("gjz_taken", 32'(bus.oUopAddr), 32'd40);
    rom[1] = enc_l(5, 14, 'h0F);
    do_reset();
    step(3); chk("gjz_fall", 32'(bus.oUopAddr), 32'd3);

    // address build, grvmem with ack after 3 cycles, shl4 view
    clear_rom();
    iBgMapOffset = 16'h1800;
    ack_lat = 3; ack_byte = 8'hA5;
    rom[0] = enc_l(1, 2, 5);
    rom[1] = enc(3, 5, 6, 2);
    rom[2] = enc(9, 0, 0, 0);
    rom[3] = enc(2, 5, 10, 0);
    do_reset();
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 1) chk("vaddr_sum", 32'(bus.oVmemAddr), 32'h1805);
      if (bus.oVmemReq) reqs++;
    end
    chk("req_cycles", 32'(reqs), 32'd3);
    chk("vdata_shl4", 32'(bus.oVmemAddr), 32'h0A50);

    // gwbg strobe
    clear_rom();
    rom[0] = enc_l(1, 11, 'h3C);
    rom[1] = enc_l(1, 12, 'hC3);
    rom[2] = enc_l(1, 4, 32);
    rom[3] = enc(10, 0, 0, 0);
    do_reset();
    step(4);
    chk("wbg_strobe", 32'(bus.oBgWrite),    32'd1);
    chk("wbg_data",   32'(bus.oBgData),     32'h3CC3);
    chk("wbg_sel",    32'(bus.oBgBlockSel), 32'd32);
    step(1); chk("wbg_once", 32'(bus.oBgWrite), 32'd0);

    // reset during VWAIT with a simultaneous ack
    clear_rom();
    ack_lat = 200; ack_byte = 8'h77;
    rom[0] = enc(9, 0, 0, 0);
    do_reset();
    step(1); chk("vw_req", 32'(bus.oVmemReq), 32'd1);
    Reset = 1'b1; force_ack = 1'b1;
    step(1);
    force_ack = 1'b0;
    chk("vw_rst_req", 32'(bus.oVmemReq),  32'd0);
    chk("vw_rst_pc",  32'(bus.oUopAddr),  32'd0);
    rom[0] = enc_l(1, 5, 'h3FF);
    rom[1] = enc(2, 5, 9, 0);
    Reset = 1'b0;
    step(2); chk("vw_vdata0", 32'(bus.oVmemAddr), 32'd0);

    // PC wrap 255 -> 0
    clear_rom();
    rom[0] = enc_l(8, 0, 255);
    do_reset();
    step(1); chk("pc_255", 32'(bus.oUopAddr), 32'd255);
    step(1); chk("pc_wrap", 32'(bus.oUopAddr), 32'd0);

    // illegal opcode 31
    clear_rom();
    rom[0] = enc_l(1, 13, 'h55);
    rom[1] = enc_l(31, 13, 'h3FF);
    do_reset();
    step(2);
    chk("ill_pulse", 32'(oIllegalOp), 32'd1);
    chk("ill_ly",    32'(oLy),        32'h55);
    step(1); chk("ill_once", 32'(oIllegalOp), 32'd0);

    // write to read-only vmem_data is dropped
    clear_rom();
    ack_lat = 1; ack_byte = 8'h5A;
    rom[0] = enc(9, 0, 0, 0);
    rom[1] = enc_l(1, 14, 7);
    rom[2] = enc(2, 9, 14, 0);
    rom[3] = enc(2, 5, 9, 0);
    do_reset();
    step(6); chk("ro_vdata", 32'(bus.oVmemAddr), 32'h5A);

    // randomized programs, enable gaps, varying ack latency, spurious acks
    ack_rand = 1'b1; rand_lat = 1'b1; spurious = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = rand_uop();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
        step(1);
        iEnable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) begin
          t = $urandom;
          iBgMapOffset  = t[15:0];
          iBgTileOffset = t[31:16];
        end
      end
      iEnable = 1'b1;
    end

    step(1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
